// File: rtl/ap_pkg.sv
// Shared definitions for the automata-processor report path: symbol width
// and the packed report record layout {offset, reports, character}.
package ap_pkg;

    localparam int SYMBOL_W          = 16;
    localparam int DEF_OFFSET_W      = 32;
    localparam int DEF_NUM_REPORTERS = 2;

    typedef struct packed {
        logic [DEF_OFFSET_W-1:0]      offset;
        logic [DEF_NUM_REPORTERS-1:0] reports;
        logic [SYMBOL_W-1:0]          character;
    } report_rec_t;

    localparam int REC_W = $bits(report_rec_t);

    // Record width for non-default offset / reporter widths; same field order.
    function automatic int rec_width(input int offset_w, input int num_reporters);
        return offset_w + num_reporters + SYMBOL_W;
    endfunction

endpackage

// File: rtl/report_fifo.sv
// Show-ahead FIFO with registered storage and an explicit occupancy counter;
// a push into a full FIFO is accepted only when a pop happens the same cycle.
module report_fifo #(
    parameter int W     = ap_pkg::REC_W,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             valid,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full  = (count_q == LVL_W'(DEPTH));
    assign valid = (count_q != '0);
    assign level = count_q;
    // Gate the head so an empty FIFO presents all-zero fields.
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop_en   = pop && valid && !flush;
        push_en  = push && !flush && (!full || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_d = count_q + 1'b1;
            else if (pop_en && !push_en) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being
    // overwritten is the head that leaves on this same edge.
    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/report_collector.sv
// Numbers incoming symbols, captures a record whenever any reporting STE fires,
// and queues records for the host with drop accounting and sticky status.
module report_collector
    import ap_pkg::*;
#(
    parameter int NUM_REPORTERS = 2,
    parameter int OFFSET_W      = 32,
    parameter int DEPTH         = 16,
    parameter int DROP_W        = 16,
    localparam int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     flush,
    input  logic                     charValid,
    input  logic [SYMBOL_W-1:0]      character,
    input  logic [NUM_REPORTERS-1:0] reports,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [OFFSET_W-1:0]      outOffset,
    output logic [NUM_REPORTERS-1:0] outReports,
    output logic [SYMBOL_W-1:0]      outCharacter,
    output logic                     overflow,
    output logic                     offsetWrapped,
    output logic [DROP_W-1:0]        dropCount,
    output logic [LVL_W-1:0]         level
);

    localparam int RW = rec_width(OFFSET_W, NUM_REPORTERS);

    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                wrapped_q, wrapped_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_valid;
    logic [RW-1:0] fifo_wdata;
    logic [RW-1:0] fifo_rdata;

    assign push       = charValid && (|reports);
    assign pop        = fifo_valid && outReady;
    assign fifo_wdata = {offset_q, reports, character};

    report_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetN (resetN),
        .flush  (flush),
        .push   (push),
        .wdata  (fifo_wdata),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .valid  (fifo_valid),
        .full   (fifo_full),
        .level  (level)
    );

    always_comb begin
        offset_d   = offset_q;
        wrapped_d  = wrapped_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush) begin
            offset_d   = '0;
            wrapped_d  = 1'b0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (charValid) begin
                offset_d = offset_q + 1'b1;
                if (&offset_q) wrapped_d = 1'b1;
            end
            // A full FIFO only loses the record when nothing leaves this cycle.
            if (push && fifo_full && !pop) begin
                overflow_d = 1'b1;
                if (!(&drop_q)) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            offset_q   <= '0;
            wrapped_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            offset_q   <= offset_d;
            wrapped_q  <= wrapped_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign outValid                               = fifo_valid;
    assign {outOffset, outReports, outCharacter}  = fifo_rdata;
    assign overflow                               = overflow_q;
    assign offsetWrapped                          = wrapped_q;
    assign dropCount                              = drop_q;

endmodule

// File: tb/tb_report_collector.sv
// Directed scenarios plus random traffic for report_collector, checked every
// cycle against a queue-based reference model of the record stream.
module tb_report_collector;

    localparam int NR    = 2;
    localparam int OW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          resetN;
    logic          flush;
    logic          charValid;
    logic [15:0]   character;
    logic [NR-1:0] reports;
    logic          outValid;
    logic          outReady;
    logic [OW-1:0] outOffset;
    logic [NR-1:0] outReports;
    logic [15:0]   outCharacter;
    logic          overflow;
    logic          offsetWrapped;
    logic [DW-1:0] dropCount;
    logic [LW-1:0] level;

    always #5 clock = ~clock;

    report_collector #(
        .NUM_REPORTERS (NR),
        .OFFSET_W      (OW),
        .DEPTH         (DEPTH),
        .DROP_W        (DW)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .flush         (flush),
        .charValid     (charValid),
        .character     (character),
        .reports       (reports),
        .outValid      (outValid),
        .outReady      (outReady),
        .outOffset     (outOffset),
        .outReports    (outReports),
        .outCharacter  (outCharacter),
        .overflow      (overflow),
        .offsetWrapped (offsetWrapped),
        .dropCount     (dropCount),
        .level         (level)
    );

    typedef struct packed {
        logic [OW-1:0] off;
        logic [NR-1:0] rep;
        logic [15:0]   ch;
    } rec_t;

    rec_t mq[$];
    int   m_off;
    bit   m_wrap;
    bit   m_ovf;
    int   m_drop;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_off  = 0;
        m_wrap = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic compare_all(input string tag);
        rec_t head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check({tag, ".valid"},   32'(outValid),      32'(mq.size() > 0));
        check({tag, ".level"},   32'(level),         32'(mq.size()));
        check({tag, ".offset"},  32'(outOffset),     32'(head.off));
        check({tag, ".reports"}, 32'(outReports),    32'(head.rep));
        check({tag, ".char"},    32'(outCharacter),  32'(head.ch));
        check({tag, ".ovf"},     32'(overflow),      32'(m_ovf));
        check({tag, ".wrap"},    32'(offsetWrapped), 32'(m_wrap));
        check({tag, ".drop"},    32'(dropCount),     32'(m_drop));
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, then compare.
    task automatic cycle(input string tag, input logic f, input logic cv,
                         input logic [15:0] c, input logic [NR-1:0] r, input logic rdy);
        bit   pop, full, push;
        rec_t rec;
        flush = f; charValid = cv; character = c; reports = r; outReady = rdy;
        pop  = rdy && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        push = cv && (r != 0);
        rec  = '{off: OW'(m_off), rep: r, ch: c};
        if (f) begin
            model_reset();
        end else begin
            if (pop) mq.delete(0);
            if (push) begin
                if (!full || pop) mq.push_back(rec);
                else begin
                    m_ovf = 1;
                    if (m_drop < (1 << DW) - 1) m_drop++;
                end
            end
            if (cv) begin
                if (m_off == (1 << OW) - 1) m_wrap = 1;
                m_off = (m_off + 1) % (1 << OW);
            end
        end
        @(posedge clock);
        @(negedge clock);
        compare_all(tag);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 16'h0, '0, 1);
    endtask

    initial begin
        resetN = 0; flush = 0; charValid = 0; character = '0; reports = '0; outReady = 0;
        model_reset();
        repeat (3) @(negedge clock);
        compare_all("reset");
        resetN = 1;

        // 1: single report on the third symbol
        for (int i = 0; i < 5; i++) begin
            cycle("t1", 0, 1, (i == 2) ? 16'h4343 : 16'($urandom), (i == 2) ? 2'b10 : 2'b00, 0);
            if (i == 1) check("t1.early_valid", 32'(outValid), 32'd0);
            if (i == 2) begin
                check("t1.valid", 32'(outValid), 32'd1);
                check("t1.off", 32'(outOffset), 32'd2);
                check("t1.rep", 32'(outReports), 32'h2);
                check("t1.chr", 32'(outCharacter), 32'h4343);
            end
        end
        check("t1.level", 32'(level), 32'd1);
        drain("t1d", 1);

        // 2: reports ignored without charValid
        cycle("t2f", 1, 0, 16'h0, '0, 0);
        for (int i = 0; i < 3; i++) cycle("t2", 0, 0, 16'h1111, 2'b11, 0);
        check("t2.none", 32'(level), 32'd0);
        cycle("t2", 0, 1, 16'h2222, 2'b01, 0);
        check("t2.off", 32'(outOffset), 32'd0);
        check("t2.level", 32'(level), 32'd1);
        drain("t2d", 1);

        // 3: overflow with outReady low
        cycle("t3f", 1, 0, 16'h0, '0, 0);
        for (int i = 0; i < 20; i++) cycle("t3", 0, 1, 16'(i), 2'b11, 0);
        check("t3.level", 32'(level), 32'd16);
        check("t3.ovf", 32'(overflow), 32'd1);
        check("t3.drop", 32'(dropCount), 32'd4);

        // 4: push while full with a pop is accepted
        cycle("t4", 0, 1, 16'hBEEF, 2'b01, 1);
        check("t4.level", 32'(level), 32'd16);
        check("t4.drop", 32'(dropCount), 32'd4);
        check("t4.head", 32'(outOffset), 32'd1);
        drain("t4d", 16);

        // 5: offset wrap
        cycle("t5f", 1, 0, 16'h0, '0, 0);
        for (int i = 0; i < 18; i++) begin
            cycle("t5", 0, 1, 16'h5500 + 16'(i), (i == 16) ? 2'b11 : 2'b00, 0);
            if (i == 14) check("t5.nowrap", 32'(offsetWrapped), 32'd0);
            if (i == 15) check("t5.wrap", 32'(offsetWrapped), 32'd1);
        end
        check("t5.off", 32'(outOffset), 32'd0);
        drain("t5d", 1);

        // dropCount saturation
        cycle("satf", 1, 0, 16'h0, '0, 0);
        for (int i = 0; i < 40; i++) cycle("sat", 0, 1, 16'($urandom), 2'b10, 0);
        check("sat.drop", 32'(dropCount), 32'd15);

        // 6: flush beats a simultaneous push
        cycle("t6f", 1, 0, 16'h0, '0, 0);
        for (int i = 0; i < 3; i++) cycle("t6", 0, 1, 16'(i), 2'b01, 0);
        cycle("t6fl", 1, 1, 16'h6666, 2'b11, 0);
        check("t6.level", 32'(level), 32'd0);
        check("t6.valid", 32'(outValid), 32'd0);
        check("t6.ovf", 32'(overflow), 32'd0);
        cycle("t6n", 0, 1, 16'h7777, 2'b10, 0);
        check("t6.off", 32'(outOffset), 32'd0);
        cycle("t6q", 0, 1, 16'h7778, 2'b01, 0);
        cycle("t6dr", 0, 0, 16'h0, '0, 1);

        // asynchronous reset mid-drain, away from any clock edge
        outReady = 1;
        #2 resetN = 0;
        #1;
        check("arst.valid", 32'(outValid), 32'd0);
        check("arst.level", 32'(level), 32'd0);
        check("arst.off", 32'(outOffset), 32'd0);
        check("arst.chr", 32'(outCharacter), 32'd0);
        flush = 0; charValid = 0; reports = '0; outReady = 0;
        model_reset();
        @(negedge clock);
        compare_all("arst");
        resetN = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd", ($urandom_range(63) == 0), ($urandom_range(9) < 7),
                  16'($urandom), NR'($urandom), ($urandom_range(9) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
